ramdisk_dev: RTL
================

Name: ramdisk_dev

Overview:
- Storage Device #2 (RAM Disk) behind the control-signal mux; consumes the muxed s2_* command signals and returns devrdy/cmdrdy/word_st/nxm/crcerr.
- Moves words between an on-chip block RAM and Q-bus memory through the shared DMA master port.
- Block size fixed at 256 words (512 bytes).
- LBA selects the block; BA/WC/IBA/Q22 define the bus side of the transfer.

Parameters:
- LBA_BITS, 10, number of LBA bits implemented; disk holds 2**LBA_BITS blocks; RAM word address width is LBA_BITS+8.

Ports:
- clk  in  1  bus clock, 20MHz
- reset  in  1  synchronous, active-low reset
- read  in  1  level: start disk-to-memory transfer
- write  in  1  level: start memory-to-disk transfer
- ba  in  22  bus byte address; bit 0 ignored
- lba  in  32  linear block address
- wc  in  16  word count, unsigned; 0 = no words
- iba  in  1  inhibit bus address increment
- q22  in  1  1 = 22-bit addressing, 0 = 18-bit addressing
- devrdy  out  1  device present and ready
- cmdrdy  out  1  idle and accepting a command
- word_st  out  1  one-cycle strobe per word moved
- nxm  out  1  non-existent memory or out-of-range block; sticky
- crcerr  out  1  tied 0
- dma_req  out  1  DMA cycle request
- dma_wr  out  1  1 = write to bus memory (disk read), 0 = read bus memory
- dma_addr  out  22  DMA byte address, bit 0 = 0
- dma_wdata  out  16  data to bus memory
- dma_rdata  in  16  data from bus memory; valid with dma_ack
- dma_ack  in  1  DMA cycle complete; one-cycle pulse
- dma_nxm  in  1  DMA cycle timed out; one-cycle pulse, replaces dma_ack
- ram_addr  out  LBA_BITS+8  block RAM word address
- ram_wdata  out  16  block RAM write data
- ram_we  out  1  block RAM write enable
- ram_rdata  in  16  block RAM read data; 1-cycle registered latency

Behaviour:
- Reset (reset==0):
  - devrdy=0, cmdrdy=0, word_st=0, nxm=0, dma_req=0, ram_we=0, dma_addr=0, dma_wdata=0, ram_addr=0.
  - armed=0; state IDLE.
  - Applies immediately mid-transfer; any DMA cycle in flight is abandoned, with no further RAM write.
- First cycle after reset release: devrdy=1 and stays 1. cmdrdy=1 whenever state==IDLE and reset released.
- Arming: armed sets on any cycle with read==0 && write==0. A command is accepted only in IDLE with armed==1, so a held read/write never restarts a finished transfer.
- Accept (IDLE, armed, read|write):
  - Latches ba[21:1], wc, iba, q22, lba, direction; read wins if both are high.
  - Clears nxm and armed.
  - Word index := 0; next state START; cmdrdy=0 from the next cycle.
- START:
  - lba >= 2**LBA_BITS (any upper bit set): nxm=1, go DONE.
  - wc==0: go DONE.
  - Otherwise read -> RD_RAM, write -> WR_DMA.
- RAM address: {lba[LBA_BITS-1:0],8'h00} + index, width LBA_BITS+8.
  - If the addition carries out (transfer runs off the end of the disk), the next word is not started: nxm=1, go DONE.
- RD_RAM: drive ram_addr for 1 cycle -> RD_WAIT: capture ram_rdata into dma_wdata -> RD_DMA.
- RD_DMA: dma_req=1, dma_wr=1 held until dma_ack or dma_nxm.
- WR_DMA: dma_req=1, dma_wr=0 held until dma_ack (capture dma_rdata) or dma_nxm.
  - On ack -> WR_RAM: ram_we=1 for exactly 1 cycle with ram_wdata=captured word.
- Word completion: the cycle of dma_ack (read) or ram_we (write).
  - word_st=1 for that cycle only.
  - index++ and remaining--.
  - Bus address advances by 2 unless iba.
  - Remaining==0 -> DONE, else the next word's first state.
- Bus address arithmetic:
  - q22=1: 22-bit wrap, 3FFFFE -> 000000.
  - q22=0: 18-bit wrap, 777776 octal -> 0; dma_addr[21:18]=0 always.
- dma_nxm on any cycle: nxm=1, dma_req drops the next cycle, no word_st, no RAM write, go DONE.
- DONE: 1 cycle, then IDLE (cmdrdy=1). nxm holds until the next accept or reset.
- Throughput: read 4 cycles/word + DMA wait; write 3 cycles/word + DMA wait.
- dma_addr and dma_wr are stable whenever dma_req=1.

Optional Feature:
- Macro: RAMDISK_ZERO_FILL_EN.
- Defined: after a write whose final word leaves a block partially written (index mod 256 != 0), state ZFILL writes 16'h0000 to each remaining word of that block.
  - One ram_we per cycle, no word_st, then DONE.
  - A write with nxm set does not zero-fill.
- Not defined: no ZFILL state; the remainder of the block keeps its old contents.

Test Plan:
- Reset, then release -> devrdy=1 and cmdrdy=1 on the first cycle after release; all other outputs 0.
- Write: lba=5, ba=001000, wc=3, q22=1; DMA returns 1111/2222/3333 -> RAM words 0x500..0x502 written, 3 word_st pulses, dma_addr 001000/001002/001004, cmdrdy returns 1, nxm=0. Read back the same block to ba=002000 -> dma_wdata 1111/2222/3333.
- q22=0, ba=777776 octal, wc=2, iba=0 -> dma_addr 777776 then 000000. Same transfer with iba=1 -> both cycles at 777776.
- dma_nxm on the 2nd word of wc=4 -> exactly 1 word_st, nxm=1 until the next accepted command, dma_req low the next cycle. Read held high through completion -> no restart until read is seen low.
- lba=2**LBA_BITS -> nxm=1, no dma_req, cmdrdy back to 1 within 3 cycles. lba=2**LBA_BITS-1, wc=300 -> 256 words moved, then nxm=1.
- RAMDISK_ZERO_FILL_EN defined, write wc=10 at lba=1 -> words 0x10A..0x1FF written 0, 10 word_st only. Macro undefined -> those words unchanged.

Source files
------------

// File: rtl/ramdisk_dev.sv
`default_nettype none
// ============================================================================
//  Module   : ramdisk_dev
//  Purpose  : RAM disk storage device. Moves 16-bit words between an on-chip
//             block RAM (256-word blocks selected by lba) and bus memory
//             through a DMA master port.
//  Ports    : clk, reset (sync, active-low)
//             command  : read, write, ba, lba, wc, iba, q22
//             status   : devrdy, cmdrdy, word_st, nxm, crcerr
//             DMA      : dma_req, dma_wr, dma_addr, dma_wdata, dma_rdata,
//                        dma_ack, dma_nxm
//             blockRAM : ram_addr, ram_wdata, ram_we, ram_rdata (1-cycle read)
//  Options  : RAMDISK_ZERO_FILL_EN - zero the unwritten tail of the last
//             block touched by a write.
//  Revision : 1.0 - initial release
// ============================================================================
module ramdisk_dev #(
    parameter int LBA_BITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [21:0]           ba,
    input  logic [31:0]           lba,
    input  logic [15:0]           wc,
    input  logic                  iba,
    input  logic                  q22,
    output logic                  devrdy,
    output logic                  cmdrdy,
    output logic                  word_st,
    output logic                  nxm,
    output logic                  crcerr,
    output logic                  dma_req,
    output logic                  dma_wr,
    output logic [21:0]           dma_addr,
    output logic [15:0]           dma_wdata,
    input  logic [15:0]           dma_rdata,
    input  logic                  dma_ack,
    input  logic                  dma_nxm,
    output logic [LBA_BITS+7:0]   ram_addr,
    output logic [15:0]           ram_wdata,
    output logic                  ram_we,
    input  logic [15:0]           ram_rdata
);

    localparam int AW = LBA_BITS + 8;
    // Sum width: wide enough for base + 16-bit index plus a carry bit.
    localparam int SW = ((AW > 16) ? AW : 16) + 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_START   = 4'd1;
    localparam logic [3:0] S_RD_RAM  = 4'd2;
    localparam logic [3:0] S_RD_WAIT = 4'd3;
    localparam logic [3:0] S_RD_DMA  = 4'd4;
    localparam logic [3:0] S_WR_DMA  = 4'd5;
    localparam logic [3:0] S_WR_RAM  = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
`ifdef RAMDISK_ZERO_FILL_EN
    localparam logic [3:0] S_ZFILL   = 4'd8;
`endif

    logic [3:0]    r_state;
    logic          r_devrdy;
    logic          r_cmdrdy;
    logic          r_nxm;
    logic          r_armed;
    logic          r_dma_req;
    logic          r_dma_wr;      // also the latched direction: 1 = disk read
    logic [21:0]   r_dma_addr;
    logic [15:0]   r_dma_wdata;
    logic [AW-1:0] r_ram_addr;
    logic [15:0]   r_ram_wdata;
    logic          r_ram_we;
    logic          r_iba;
    logic          r_q22;
    logic [31:0]   r_lba;
    logic [15:0]   r_rem;
    logic [15:0]   r_idx;

    logic [AW-1:0] w_base;
    logic [SW-1:0] w_sum_cur;
    logic [SW-1:0] w_sum_nxt;
    logic          w_carry_nxt;
    logic [15:0]   w_idx_nxt;
    logic [15:0]   w_rem_nxt;
    logic          w_last;
    logic          w_lba_oor;
    logic [21:0]   w_addr_nxt;
    logic          w_accept;

    assign w_base      = {r_lba[LBA_BITS-1:0], 8'h00};
    assign w_sum_cur   = SW'(w_base) + SW'(r_idx);
    assign w_sum_nxt   = SW'(w_base) + SW'(r_idx) + SW'(1);
    // Any bit above the RAM address width means the next word is off the disk.
    assign w_carry_nxt = |w_sum_nxt[SW-1:AW];
    assign w_idx_nxt   = r_idx + 16'd1;
    assign w_rem_nxt   = r_rem - 16'd1;
    assign w_last      = (r_rem == 16'd1);
    assign w_lba_oor   = (r_lba >> LBA_BITS) != 32'd0;
    assign w_accept    = (r_state == S_IDLE) && r_armed && (read || write);

    // 18-bit mode keeps the upper four address bits at zero and wraps at 256 KB.
    always_comb begin
        w_addr_nxt = r_dma_addr;
        if (!r_iba) begin
            if (r_q22) w_addr_nxt = r_dma_addr + 22'd2;
            else       w_addr_nxt = {4'b0000, r_dma_addr[17:0] + 18'd2};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_devrdy    <= 1'b0;
            r_cmdrdy    <= 1'b0;
            r_nxm       <= 1'b0;
            r_armed     <= 1'b0;
            r_dma_req   <= 1'b0;
            r_dma_wr    <= 1'b0;
            r_dma_addr  <= '0;
            r_dma_wdata <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_iba       <= 1'b0;
            r_q22       <= 1'b0;
            r_lba       <= '0;
            r_rem       <= '0;
            r_idx       <= '0;
        end else begin
            r_devrdy <= 1'b1;
            // A command level must be seen low before another is taken.
            if (!read && !write) r_armed <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_cmdrdy <= 1'b1;
                    if (w_accept) begin
                        r_cmdrdy   <= 1'b0;
                        r_armed    <= 1'b0;
                        r_nxm      <= 1'b0;
                        r_dma_wr   <= read;
                        r_dma_addr <= q22 ? (ba & 22'h3FFFFE) : (ba & 22'h03FFFE);
                        r_rem      <= wc;
                        r_idx      <= '0;
                        r_iba      <= iba;
                        r_q22      <= q22;
                        r_lba      <= lba;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_lba_oor) begin
                        r_nxm   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_rem == 16'd0) begin
                        r_state <= S_DONE;
                    end else if (r_dma_wr) begin
                        r_ram_addr <= w_sum_cur[AW-1:0];
                        r_state    <= S_RD_RAM;
                    end else begin
                        r_dma_req <= 1'b1;
                        r_state   <= S_WR_DMA;
                    end
                end
                S_RD_RAM: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_dma_wdata <= ram_rdata;
                    r_dma_req   <= 1'b1;
                    r_state     <= S_RD_DMA;
                end
                S_RD_DMA: begin
                    if (dma_nxm) begin
                        r_dma_req <= 1'b0;
                        r_nxm     <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (dma_ack) begin
                        r_dma_req  <= 1'b0;
                        r_idx      <= w_idx_nxt;
                        r_rem      <= w_rem_nxt;
                        r_dma_addr <= w_addr_nxt;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else if (w_carry_nxt) begin
                            r_nxm   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ram_addr <= w_sum_nxt[AW-1:0];
                            r_state    <= S_RD_RAM;
                        end
                    end
                end
                S_WR_DMA: begin
                    if (dma_nxm) begin
                        r_dma_req <= 1'b0;
                        r_nxm     <= 1'b1;
                        r_state   <= S_DONE;
                    end else if (dma_ack) begin
                        r_dma_req   <= 1'b0;
                        r_ram_wdata <= dma_rdata;
                        r_ram_addr  <= w_sum_cur[AW-1:0];
                        r_ram_we    <= 1'b1;
                        r_state     <= S_WR_RAM;
                    end
                end
                S_WR_RAM: begin
                    r_ram_we   <= 1'b0;
                    r_idx      <= w_idx_nxt;
                    r_rem      <= w_rem_nxt;
                    r_dma_addr <= w_addr_nxt;
                    if (w_last) begin
`ifdef RAMDISK_ZERO_FILL_EN
                        if (w_idx_nxt[7:0] != 8'h00) begin
                            r_ram_we    <= 1'b1;
                            r_ram_wdata <= 16'h0000;
                            r_ram_addr  <= w_sum_nxt[AW-1:0];
                            r_state     <= S_ZFILL;
                        end else begin
                            r_state <= S_DONE;
                        end
`else
                        r_state <= S_DONE;
`endif
                    end else if (w_carry_nxt) begin
                        r_nxm   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_dma_req <= 1'b1;
                        r_state   <= S_WR_DMA;
                    end
                end
`ifdef RAMDISK_ZERO_FILL_EN
                // r_idx is the word being zeroed this cycle; stop at block end.
                S_ZFILL: begin
                    r_idx <= w_idx_nxt;
                    if (w_idx_nxt[7:0] == 8'h00) begin
                        r_ram_we <= 1'b0;
                        r_state  <= S_DONE;
                    end else begin
                        r_ram_addr <= w_sum_nxt[AW-1:0];
                    end
                end
`endif
                S_DONE: begin
                    r_cmdrdy <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A disk-read word completes on the ack itself, so the strobe is combinational.
    assign word_st   = reset & (((r_state == S_RD_DMA) & dma_ack & ~dma_nxm) |
                                (r_state == S_WR_RAM));
    assign devrdy    = r_devrdy;
    assign cmdrdy    = r_cmdrdy;
    assign nxm       = r_nxm;
    assign crcerr    = 1'b0;
    assign dma_req   = r_dma_req;
    assign dma_wr    = r_dma_wr;
    assign dma_addr  = r_dma_addr;
    assign dma_wdata = r_dma_wdata;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;

endmodule
`default_nettype wire
